fram_arbiter: RTL
=================

# fram_arbiter

Two-port arbiter and sequencer for the shared SPI FRAM interface. Port 0 serves the SUBLEQ CPU core and port 1 serves the program loader/debug path. Each port uses a level request and done-pulse handshake. The block issues one-cycle `start` pulses to the FRAM interface, holds its address, data and write-enable stable until `done`, and aborts hung transfers with a bounded timeout.

## Interface
- `ADDR_W`, 16, address width (FRAM word address)
- `DATA_W`, 16, data word width
- `TIMEOUT`, 1023, maximum WAIT cycles before abort (≥2); counter width is clog2(TIMEOUT+1)
- `clk`  in  1  clock; single clock domain
- `rst_n`  in  1  reset; **synchronous, active-low**
- `p0_req`, `p1_req`  in  1  level request; held until that port's `done`
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read; stable while `req` is high
- `p0_addr`, `p1_addr`  in  ADDR_W  word address; stable while `req` is high
- `p0_wdata`, `p1_wdata`  in  DATA_W  write data; stable while `req` is high
- `p0_done`, `p1_done`  out  1  one-cycle completion pulse
- `p0_err`, `p1_err`  out  1  pulses with `done` when the transfer timed out
- `p0_rdata`, `p1_rdata`  out  DATA_W  read data; updated only on successful reads; held otherwise
- `mem_start`  out  1  one-cycle start pulse to the FRAM interface
- `mem_we`  out  1  write-enable to the FRAM interface
- `mem_addr`  out  ADDR_W  address to the FRAM interface
- `mem_wdata`  out  DATA_W  write data to the FRAM interface
- `mem_done`  in  1  FRAM interface completion pulse
- `mem_rdata`  in  DATA_W  FRAM read data; valid when `mem_done` is high
- `busy`  out  1  high in every state except IDLE
- `grant`  out  1  port owning the current or last transaction

## Operation
- **States:** IDLE, START, WAIT, DONE, DRAIN.
- **IDLE → START:** taken when any `req` is high.
  - Winner: if only one port requests, that port wins. If both request, the winner is the port ≠ `last`.
  - `last` resets to 1, so port 0 wins the first tie.
  - On the transition, latch the winner's addr, wdata and we into `mem_addr`, `mem_wdata` and `mem_we`; set `grant` and `last`.
- **START → WAIT:** `mem_start` = 1 for exactly this cycle. Clear the timeout counter.
- **WAIT:** `mem_start` = 0. The counter increments every cycle.
  - If `mem_done` = 1: if `mem_we` = 0, capture `mem_rdata` into the granted port's `rdata`. Go to DONE with err = 0.
  - Else if counter = TIMEOUT−1: go to DONE with err = 1 and set the drain flag. `rdata` is unchanged.
  - `mem_done` takes precedence over timeout in the same cycle.
- **DONE:** the granted port's `done` = 1 and its `err` = the latched err, for one cycle.
  - Without the drain flag, next state is IDLE.
  - With the drain flag, next state is DRAIN and the counter is cleared.
- **DRAIN:** keeps `mem_*` stable and `mem_start` = 0. Returns to IDLE on `mem_done` or when the counter reaches TIMEOUT−1. No `done` or `err` pulse is issued in DRAIN.
- **Ignored inputs:**
  - `mem_done` in IDLE, START or DONE.
  - `req` of any port outside IDLE.
  - Changes to a port's addr, wdata or we after latching.
- **Back-to-back requests:** a requester keeping `req` high after `done` issues a new request. Round-robin rotates to the other port if it is also requesting.
- **Reset:** when `rst_n` = 0 at a rising edge:
  - state → IDLE; `last` → 1; counter and drain flag → 0.
  - All outputs → 0: `mem_start`, `mem_we`, `mem_addr`, `mem_wdata`, both `done`, both `err`, both `rdata`, `busy`, `grant`.
  - Reset mid-transaction abandons the transaction with no `done` pulse.

## Timing
- All outputs are registered.
- Let the first IDLE cycle where `req` is sampled high be cycle n. Then `mem_start` is high in n+1, and `busy` and `grant` are valid from n+1.
- `mem_done` sampled in WAIT cycle k → the port's `done` (and `rdata` for reads) is valid in cycle k+1. The port's `rdata` is stable from then until its next successful read.
- Minimum request-to-done latency with `mem_done` in the first WAIT cycle: `req`@n → `done`@n+3.
- Minimum spacing between `mem_start` pulses is 4 cycles.
- Requester rule: sample `done` at the end of the DONE cycle and drop `req` on that edge. The arbiter is back in IDLE on that same edge and sees `req` low.
- Timeout: `err` and `done` assert TIMEOUT+1 cycles after the `mem_start` cycle.

## Test plan
- **Single read:** `p0_req` with addr 0x0003, we = 0. FRAM model returns 0xBEEF after 5 WAIT cycles. Expect:
  - one `mem_start` pulse with `mem_addr` 0x0003;
  - `p0_done` one cycle after `mem_done`, with `p0_rdata` 0xBEEF and `p0_err` 0;
  - `p1_done` stays 0.
- **Simultaneous requests:** `p0_req` and `p1_req` rise together, both held. Expect grants in the order 0, 1, 0, 1 over 4 transactions. Each `done` goes only to its own port.
- **Write:** `p1_req` with we = 1, addr 0x0010, wdata 0x1234. Expect:
  - `mem_we` = 1 and `mem_wdata` 0x1234, stable from START until `mem_done`;
  - `p1_rdata` unchanged after `p1_done`.
- **Timeout:** TIMEOUT = 8, model never asserts `mem_done`. Expect:
  - `p0_done` and `p0_err` high 9 cycles after `mem_start`;
  - DRAIN for 8 cycles, then IDLE;
  - a pending `p1_req` is granted only after DRAIN.
- **Done/timeout collision:** `mem_done` asserted in the WAIT cycle where counter = TIMEOUT−1. Expect `done` = 1 with `err` = 0, `rdata` captured, and no DRAIN.
- **Reset mid-transfer:** `rst_n` low for one edge while in WAIT. Expect the next cycle to be IDLE with all outputs 0 and no `done` pulse. A new `p1_req` is then granted normally.

Source files
------------

// File: rtl/fram_arbiter.sv
// Two-port round-robin arbiter and sequencer for the shared SPI FRAM interface.
// Port 0 is the SUBLEQ core and port 1 is the loader/debug path. Hung transfers are aborted and drained.
module fram_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_done,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_done,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant,
  output logic [2:0]        dbg_state
);

  // Handshake: a port holds req (with we/addr/wdata stable) until it sees its
  // one-cycle done pulse; req still high after done counts as a new request.
  // The FRAM side gets a one-cycle mem_start and answers with a one-cycle mem_done.

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               last_q, last_d;
  logic               drain_q, drain_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cnt_hit;
  logic               win;
  logic               to_err;

  logic               mem_start_d, mem_we_d, busy_d, grant_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_d, p0_rdata_d, p1_rdata_d;
  logic               p0_done_d, p1_done_d, p0_err_d, p1_err_d;

  assign cnt_hit   = (cnt_q == CNT_LAST);
  // On a tie the port that did not win last time gets the bus.
  assign win       = (p0_req && p1_req) ? ~last_q : p1_req;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      drain_q   <= 1'b0;
      cnt_q     <= '0;
      mem_start <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      p0_done   <= 1'b0;
      p1_done   <= 1'b0;
      p0_err    <= 1'b0;
      p1_err    <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
      busy      <= 1'b0;
      grant     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      drain_q   <= drain_d;
      cnt_q     <= cnt_d;
      mem_start <= mem_start_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      p0_done   <= p0_done_d;
      p1_done   <= p1_done_d;
      p0_err    <= p0_err_d;
      p1_err    <= p1_err_d;
      p0_rdata  <= p0_rdata_d;
      p1_rdata  <= p1_rdata_d;
      busy      <= busy_d;
      grant     <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (p0_req || p1_req) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (mem_done || cnt_hit) state_d = DONE;
      DONE:    state_d = drain_q ? DRAIN : IDLE;
      DRAIN:   if (mem_done || cnt_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    grant_d     = grant;
    last_d      = last_q;
    p0_rdata_d  = p0_rdata;
    p1_rdata_d  = p1_rdata;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    to_err      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (state_d == START) begin
          grant_d     = win;
          last_d      = win;
          mem_we_d    = win ? p1_we    : p0_we;
          mem_addr_d  = win ? p1_addr  : p0_addr;
          mem_wdata_d = win ? p1_wdata : p0_wdata;
        end
      end
      START: cnt_d = '0;
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A completion in the last WAIT cycle still counts as success.
        if (mem_done) begin
          if (!mem_we) begin
            if (grant) p1_rdata_d = mem_rdata;
            else       p0_rdata_d = mem_rdata;
          end
        end else if (cnt_hit) begin
          to_err  = 1'b1;
          drain_d = 1'b1;
        end
      end
      DONE: begin
        if (drain_q) begin
          cnt_d   = '0;
          drain_d = 1'b0;
        end
      end
      DRAIN: cnt_d = cnt_q + CNT_W'(1);
      default: ;
    endcase
    mem_start_d = (state_d == START);
    busy_d      = (state_d != IDLE);
    p0_done_d   = (state_q == WAIT) && (state_d == DONE) && !grant;
    p1_done_d   = (state_q == WAIT) && (state_d == DONE) &&  grant;
    p0_err_d    = to_err && !grant;
    p1_err_d    = to_err &&  grant;
  end

endmodule
